// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
//   W_BYTE/W_HALF/W_WORD : access-width codes carried down from decode
//   REG_ADDR_W           : register-file address width
//   is_misaligned()      : alignment rule for a width code and byte lane
package mips_pkg;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b11;

   localparam int REG_ADDR_W = 5;

   // The reserved code 2'b10 falls into the default branch and is treated as a word.
   function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
      logic mis;
      case (width)
         W_BYTE:  mis = 1'b0;
         W_HALF:  mis = lane[0];
         default: mis = (lane != 2'b00);
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/data_memory.sv
// Data memory array: 2^NB_ADDR words of NB_DATA bits.
//   clk, i_rst          : clock, async active-high reset (debug port and write gate only)
//   i_wr_en/be/addr/data: single write port with per-lane byte enables
//   i_rd_addr/o_rd_data : combinational read port for the MEM stage
//   i_dbg_addr/o_dbg_data: registered read port for the debug unit
module data_memory #(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic               clk,
   input  logic               i_rst,
   input  logic               i_wr_en,
   input  logic [3:0]         i_wr_be,
   input  logic [NB_ADDR-1:0] i_wr_addr,
   input  logic [NB_DATA-1:0] i_wr_data,
   input  logic [NB_ADDR-1:0] i_rd_addr,
   output logic [NB_DATA-1:0] o_rd_data,
   input  logic [NB_ADDR-1:0] i_dbg_addr,
   output logic [NB_DATA-1:0] o_dbg_data
);

   logic [NB_DATA-1:0] mem_q [2**NB_ADDR];
   logic [NB_DATA-1:0] dbg_data_d;
   logic [NB_DATA-1:0] dbg_data_q;

   // Contents are deliberately not reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (i_wr_en && !i_rst) begin
         for (int b = 0; b < 4; b++) begin
            if (i_wr_be[b]) begin
               mem_q[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
         end
      end
   end

   assign o_rd_data = mem_q[i_rd_addr];

   // Sampled before this edge's write lands, so a same-address collision returns old data.
   always_comb begin
      dbg_data_d = mem_q[i_dbg_addr];
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         dbg_data_q <= '0;
      end else begin
         dbg_data_q <= dbg_data_d;
      end
   end

   assign o_dbg_data = dbg_data_q;

endmodule

// File: rtl/memory_access.sv
// MEM stage of the 5-stage MIPS pipeline.
// Performs byte/half/word loads and stores against data_memory, checks
// alignment, extends load data and registers the MEM/WB latch.
//   clk, i_rst        : clock, async active-high reset
//   i_stall, i_halt   : freeze the stage (debug port stays live)
//   i_alu_result ...  : EX/MEM latch inputs
//   o_write_reg ...   : MEM/WB latch outputs, o_misaligned flags the latched instruction
//   i_dbg_addr/o_dbg_data : registered debug word read
module memory_access
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32,
   parameter int NB_ADDR = 8
) (
   input  logic                  clk,
   input  logic                  i_rst,
   input  logic                  i_stall,
   input  logic                  i_halt,
   input  logic [NB_DATA-1:0]    i_alu_result,
   input  logic [NB_DATA-1:0]    i_store_data,
   input  logic [REG_ADDR_W-1:0] i_write_reg,
   input  logic                  i_mem2reg,
   input  logic                  i_memRead,
   input  logic                  i_memWrite,
   input  logic                  i_regWrite,
   input  logic [1:0]            i_width,
   input  logic                  i_unsigned,
   input  logic [NB_ADDR-1:0]    i_dbg_addr,
   output logic [REG_ADDR_W-1:0] o_write_reg,
   output logic                  o_mem2reg,
   output logic                  o_regWrite,
   output logic [NB_DATA-1:0]    o_alu_result,
   output logic [NB_DATA-1:0]    o_read_data,
   output logic                  o_misaligned,
   output logic [NB_DATA-1:0]    o_dbg_data
);

   logic [NB_ADDR-1:0]    word_idx;
   logic [1:0]            lane;
   logic                  frozen;
   logic                  misal;
   logic                  wr_en;
   logic [3:0]            wr_be;
   logic [NB_DATA-1:0]    wr_data;
   logic [NB_DATA-1:0]    rd_word;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [NB_DATA-1:0]    ld_ext;

   logic [REG_ADDR_W-1:0] write_reg_d,  write_reg_q;
   logic                  mem2reg_d,    mem2reg_q;
   logic                  regwrite_d,   regwrite_q;
   logic [NB_DATA-1:0]    alu_result_d, alu_result_q;
   logic [NB_DATA-1:0]    read_data_d,  read_data_q;
   logic                  misaligned_d, misaligned_q;

   // Address bits above the array are ignored, so accesses wrap.
   logic unused_addr_bits;
   assign unused_addr_bits = ^i_alu_result[NB_DATA-1:NB_ADDR+2];

   always_comb begin
      word_idx = i_alu_result[NB_ADDR+1:2];
      lane     = i_alu_result[1:0];
      frozen   = i_stall | i_halt;
      misal    = is_misaligned(i_width, lane);

      // Replicate the store data across lanes; the byte enables pick the real target.
      case (i_width)
         W_BYTE: begin
            wr_data = {4{i_store_data[7:0]}};
            wr_be   = 4'b0001 << lane;
         end
         W_HALF: begin
            wr_data = {2{i_store_data[15:0]}};
            wr_be   = lane[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wr_data = i_store_data;
            wr_be   = 4'b1111;
         end
      endcase
      wr_en = i_memWrite & ~misal & ~frozen;

      rd_byte = rd_word[8*lane +: 8];
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      case (i_width)
         W_BYTE:  ld_ext = i_unsigned ? {{(NB_DATA-8){1'b0}}, rd_byte}
                                      : {{(NB_DATA-8){rd_byte[7]}}, rd_byte};
         W_HALF:  ld_ext = i_unsigned ? {{(NB_DATA-16){1'b0}}, rd_half}
                                      : {{(NB_DATA-16){rd_half[15]}}, rd_half};
         default: ld_ext = rd_word;
      endcase

      write_reg_d  = write_reg_q;
      mem2reg_d    = mem2reg_q;
      regwrite_d   = regwrite_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      misaligned_d = misaligned_q;
      if (!frozen) begin
         write_reg_d  = i_write_reg;
         mem2reg_d    = i_mem2reg;
         regwrite_d   = i_regWrite & ~(i_memRead & misal);
         alu_result_d = i_alu_result;
         // A read colliding with a write is illegal from control; the store wins, data reads 0.
         read_data_d  = (i_memRead & ~i_memWrite & ~misal) ? ld_ext : '0;
         misaligned_d = misal & (i_memRead | i_memWrite);
      end
   end

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         write_reg_q  <= '0;
         mem2reg_q    <= 1'b0;
         regwrite_q   <= 1'b0;
         alu_result_q <= '0;
         read_data_q  <= '0;
         misaligned_q <= 1'b0;
      end else begin
         write_reg_q  <= write_reg_d;
         mem2reg_q    <= mem2reg_d;
         regwrite_q   <= regwrite_d;
         alu_result_q <= alu_result_d;
         read_data_q  <= read_data_d;
         misaligned_q <= misaligned_d;
      end
   end

   data_memory #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_data_memory (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_wr_en    (wr_en),
      .i_wr_be    (wr_be),
      .i_wr_addr  (word_idx),
      .i_wr_data  (wr_data),
      .i_rd_addr  (word_idx),
      .o_rd_data  (rd_word),
      .i_dbg_addr (i_dbg_addr),
      .o_dbg_data (o_dbg_data)
   );

   assign o_write_reg  = write_reg_q;
   assign o_mem2reg    = mem2reg_q;
   assign o_regWrite   = regwrite_q;
   assign o_alu_result = alu_result_q;
   assign o_read_data  = read_data_q;
   assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
   import mips_pkg::*;

   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 8;
   localparam int NBYTES  = 4 * (2**NB_ADDR);

   logic                  clk = 1'b0;
   logic                  i_rst = 1'b0;
   logic                  i_stall = 1'b0;
   logic                  i_halt = 1'b0;
   logic [NB_DATA-1:0]    i_alu_result = '0;
   logic [NB_DATA-1:0]    i_store_data = '0;
   logic [4:0]            i_write_reg = '0;
   logic                  i_mem2reg = 1'b0;
   logic                  i_memRead = 1'b0;
   logic                  i_memWrite = 1'b0;
   logic                  i_regWrite = 1'b0;
   logic [1:0]            i_width = W_WORD;
   logic                  i_unsigned = 1'b0;
   logic [NB_ADDR-1:0]    i_dbg_addr = '0;
   logic [4:0]            o_write_reg;
   logic                  o_mem2reg;
   logic                  o_regWrite;
   logic [NB_DATA-1:0]    o_alu_result;
   logic [NB_DATA-1:0]    o_read_data;
   logic                  o_misaligned;
   logic [NB_DATA-1:0]    o_dbg_data;

   int checks = 0;
   int errors = 0;

   memory_access #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
      .clk          (clk),
      .i_rst        (i_rst),
      .i_stall      (i_stall),
      .i_halt       (i_halt),
      .i_alu_result (i_alu_result),
      .i_store_data (i_store_data),
      .i_write_reg  (i_write_reg),
      .i_mem2reg    (i_mem2reg),
      .i_memRead    (i_memRead),
      .i_memWrite   (i_memWrite),
      .i_regWrite   (i_regWrite),
      .i_width      (i_width),
      .i_unsigned   (i_unsigned),
      .i_dbg_addr   (i_dbg_addr),
      .o_write_reg  (o_write_reg),
      .o_mem2reg    (o_mem2reg),
      .o_regWrite   (o_regWrite),
      .o_alu_result (o_alu_result),
      .o_read_data  (o_read_data),
      .o_misaligned (o_misaligned),
      .o_dbg_data   (o_dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed little-endian memory with known-byte tracking.
   logic [7:0]  mem_m   [NBYTES];
   bit          known_m [NBYTES];
   logic [4:0]  e_wreg = '0;
   logic        e_m2r = 1'b0, e_rw = 1'b0, e_mis = 1'b0;
   logic [31:0] e_alu = '0, e_rd = '0, e_dbg = '0;
   bit          e_rd_known = 1'b1, e_dbg_known = 1'b1;

   function automatic int nbytes(input logic [1:0] w);
      if (w == 2'b00) return 1;
      if (w == 2'b01) return 2;
      return 4;
   endfunction

   always @(posedge clk or posedge i_rst) begin
      int a, n, d;
      bit mis, k;
      logic [31:0] v;
      if (i_rst) begin
         e_wreg = '0; e_m2r = 0; e_rw = 0; e_mis = 0;
         e_alu = '0; e_rd = '0; e_dbg = '0;
         e_rd_known = 1; e_dbg_known = 1;
      end else begin
         d = int'(i_dbg_addr) * 4;
         e_dbg = {mem_m[d+3], mem_m[d+2], mem_m[d+1], mem_m[d]};
         e_dbg_known = known_m[d] && known_m[d+1] && known_m[d+2] && known_m[d+3];
         if (!(i_stall || i_halt)) begin
            a   = int'(i_alu_result[NB_ADDR+1:0]);
            n   = nbytes(i_width);
            mis = (a % n) != 0;
            e_wreg = i_write_reg;
            e_m2r  = i_mem2reg;
            e_alu  = i_alu_result;
            e_mis  = mis && (i_memRead || i_memWrite);
            e_rw   = i_regWrite && !(i_memRead && mis);
            e_rd = '0;
            e_rd_known = 1;
            if (i_memRead && !i_memWrite && !mis) begin
               v = '0;
               k = 1;
               for (int j = 0; j < n; j++) begin
                  v = v | (32'(mem_m[a+j]) << (8*j));
                  k = k && known_m[a+j];
               end
               if (!i_unsigned && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
               e_rd = v;
               e_rd_known = k;
            end
            if (i_memWrite && !mis) begin
               for (int j = 0; j < n; j++) begin
                  mem_m[a+j]   = i_store_data[8*j +: 8];
                  known_m[a+j] = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("write_reg",  32'(o_write_reg),  32'(e_wreg));
      chk("mem2reg",    32'(o_mem2reg),    32'(e_m2r));
      chk("regWrite",   32'(o_regWrite),   32'(e_rw));
      chk("alu_result", o_alu_result,      e_alu);
      chk("misaligned", 32'(o_misaligned), 32'(e_mis));
      if (e_rd_known)  chk("read_data", o_read_data, e_rd);
      if (e_dbg_known) chk("dbg_data",  o_dbg_data,  e_dbg);
   end

   task automatic drive(input logic rd, input logic wr, input logic [1:0] w, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] wreg, input logic rw);
      i_memRead    = rd;
      i_memWrite   = wr;
      i_mem2reg    = rd;
      i_width      = w;
      i_unsigned   = uns;
      i_alu_result = addr;
      i_store_data = data;
      i_write_reg  = wreg;
      i_regWrite   = rw;
   endtask

   task automatic step(input logic rd, input logic wr, input logic [1:0] w, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wreg, input logic rw);
      drive(rd, wr, w, uns, addr, data, wreg, rw);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 i_rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("lit_rst_alu", o_alu_result, 32'h0);
      chk("lit_rst_dbg", o_dbg_data, 32'h0);
      i_rst = 1'b0;

      // Known word, then a store caught by reset must be dropped.
      step(0, 1, W_WORD, 0, 32'h10, 32'hA5A5_A5A5, 5'd1, 0);
      drive(0, 1, W_WORD, 0, 32'h10, 32'h0000_0000, 5'd2, 0);
      #2 i_rst = 1'b1;
      #1;
      chk("lit_rst_async_alu", o_alu_result, 32'h0);
      chk("lit_rst_async_wreg", 32'(o_write_reg), 32'h0);
      @(posedge clk);
      @(negedge clk);
      i_rst = 1'b0;
      step(1, 0, W_WORD, 0, 32'h10, 32'h0, 5'd3, 1);
      chk("lit_rst_drop", o_read_data, 32'hA5A5_A5A5);

      step(0, 1, W_WORD, 0, 32'h20, 32'hDEAD_BEEF, 5'd0, 0);
      step(1, 0, W_WORD, 0, 32'h20, 32'h0, 5'd7, 1);
      chk("lit_lw", o_read_data, 32'hDEAD_BEEF);
      chk("lit_lw_rw", 32'(o_regWrite), 32'h1);

      step(0, 1, W_WORD, 0, 32'h40, 32'h1122_3344, 5'd0, 0);
      step(0, 1, W_BYTE, 0, 32'h41, 32'h5566_77AA, 5'd0, 0);
      step(1, 0, W_BYTE, 0, 32'h41, 32'h0, 5'd4, 1);
      chk("lit_lb", o_read_data, 32'hFFFF_FFAA);
      step(1, 0, W_BYTE, 1, 32'h41, 32'h0, 5'd4, 1);
      chk("lit_lbu", o_read_data, 32'h0000_00AA);
      step(1, 0, W_WORD, 0, 32'h40, 32'h0, 5'd4, 1);
      chk("lit_sb_merge", o_read_data, 32'h1122_AA44);

      step(0, 1, W_WORD, 0, 32'h40, 32'h8001_FFFF, 5'd0, 0);
      step(1, 0, W_HALF, 0, 32'h42, 32'h0, 5'd5, 1);
      chk("lit_lh", o_read_data, 32'hFFFF_8001);
      step(1, 0, W_HALF, 1, 32'h42, 32'h0, 5'd5, 1);
      chk("lit_lhu", o_read_data, 32'h0000_8001);
      step(1, 0, W_WORD, 0, 32'h42, 32'h0, 5'd5, 1);
      chk("lit_mis_flag", 32'(o_misaligned), 32'h1);
      chk("lit_mis_rw", 32'(o_regWrite), 32'h0);
      chk("lit_mis_data", o_read_data, 32'h0);
      // Misaligned flag must hold across a stall.
      i_stall = 1'b1;
      step(0, 0, W_WORD, 0, 32'h0, 32'h0, 5'd0, 0);
      chk("lit_mis_hold", 32'(o_misaligned), 32'h1);
      i_stall = 1'b0;
      step(0, 1, W_HALF, 0, 32'h43, 32'h0000_1234, 5'd0, 0);
      chk("lit_sh_mis", 32'(o_misaligned), 32'h1);
      step(1, 0, W_WORD, 0, 32'h40, 32'h0, 5'd6, 1);
      chk("lit_sh_untouched", o_read_data, 32'h8001_FFFF);

      // Unaligned address without a memory access raises nothing; reserved width acts as word.
      step(0, 0, W_WORD, 0, 32'h3, 32'h0, 5'd8, 1);
      chk("lit_nomem_mis", 32'(o_misaligned), 32'h0);
      step(1, 0, 2'b10, 0, 32'h40, 32'h0, 5'd8, 1);
      chk("lit_reserved_w", o_read_data, 32'h8001_FFFF);

      // Read and write together: store lands, read data is zero.
      step(1, 1, W_WORD, 0, 32'h60, 32'h0BAD_F00D, 5'd9, 0);
      chk("lit_rdwr_data", o_read_data, 32'h0);
      step(1, 0, W_WORD, 0, 32'h60, 32'h0, 5'd9, 1);
      chk("lit_rdwr_store", o_read_data, 32'h0BAD_F00D);

      // Stall blocks the write and freezes MEM/WB.
      step(0, 1, W_WORD, 0, 32'h50, 32'hCAFE_F00D, 5'd9, 0);
      i_stall = 1'b1;
      step(0, 1, W_WORD, 0, 32'h54, 32'h0000_0000, 5'd12, 1);
      chk("lit_stall_wreg", 32'(o_write_reg), 32'd9);
      chk("lit_stall_alu", o_alu_result, 32'h50);
      i_stall = 1'b0;
      step(1, 0, W_WORD, 0, 32'h50, 32'h0, 5'd13, 1);
      chk("lit_stall_nowrite", o_read_data, 32'hCAFE_F00D);

      // Halt: stage frozen, debug port still reads.
      i_halt = 1'b1;
      i_dbg_addr = 8'h14;
      step(0, 1, W_WORD, 0, 32'h50, 32'h1111_1111, 5'd20, 1);
      chk("lit_halt_dbg", o_dbg_data, 32'hCAFE_F00D);
      chk("lit_halt_wreg", 32'(o_write_reg), 32'd13);
      i_stall = 1'b1;
      step(0, 0, W_WORD, 0, 32'h0, 32'h0, 5'd0, 0);
      chk("lit_halt_nowrite", o_dbg_data, 32'hCAFE_F00D);
      i_stall = 1'b0;
      i_halt = 1'b0;

      // Address wrap: byte 0x400 lands in word 0.
      step(0, 1, W_WORD, 0, 32'h400, 32'h1234_5678, 5'd0, 0);
      i_dbg_addr = 8'h00;
      step(0, 0, W_WORD, 0, 32'h0, 32'h0, 5'd0, 0);
      chk("lit_wrap_dbg", o_dbg_data, 32'h1234_5678);
      step(1, 0, W_WORD, 0, 32'h0, 32'h0, 5'd1, 1);
      chk("lit_wrap_lw", o_read_data, 32'h1234_5678);

      // Debug read colliding with a write returns the old word.
      step(0, 1, W_WORD, 0, 32'h0, 32'h0000_0009, 5'd0, 0);
      chk("lit_dbg_old", o_dbg_data, 32'h1234_5678);
      step(0, 0, W_WORD, 0, 32'h0, 32'h0, 5'd0, 0);
      chk("lit_dbg_new", o_dbg_data, 32'h0000_0009);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
